// File: rtl/gray_step_decoder_pkg.sv
// Shared types and default sizes for the Gray-code step decoder.
// Imported by the top and by the Gray-to-binary converter.
package gray_step_decoder_pkg;

  localparam int DEFAULT_WIDTH     = 3;
  localparam int DEFAULT_POS_WIDTH = 8;

  typedef enum logic [1:0] {
    WAIT_FIRST = 2'b00,
    TRACK      = 2'b01,
    FAULT      = 2'b10
  } state_e;

  // Classification of one accepted sample against the previous one.
  typedef enum logic [1:0] {
    STEP_NONE,
    STEP_UP,
    STEP_DOWN,
    STEP_ILLEGAL
  } step_e;

endpackage : gray_step_decoder_pkg

// File: rtl/gray_step_decoder_gray_to_bin.sv
// Combinational Gray-to-binary converter.
// Each binary bit is the XOR of all Gray bits at and above it.
module gray_to_bin #(
  parameter int WIDTH = gray_step_decoder_pkg::DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] gray_i,
  output logic [WIDTH-1:0] bin_o
);

  // A reduction per bit avoids a bit-level chain through bin_o itself.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign bin_o[i] = ^gray_i[WIDTH-1:i];
  end

endmodule : gray_to_bin

// File: rtl/gray_step_decoder.sv
// Samples a Gray code, converts it to binary and classifies each step as
// up, down, none or illegal; keeps a wrapping position and a sticky fault.
module gray_step_decoder
  import gray_step_decoder_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int POS_WIDTH = DEFAULT_POS_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     gray_in,
  input  logic                 sample_en,
  input  logic                 clear_fault,
  output logic [WIDTH-1:0]     binario,
  output logic                 up,
  output logic                 down,
  output logic                 error,
  output logic                 fault,
  output logic [POS_WIDTH-1:0] position
);

  localparam logic [WIDTH-1:0]     DIFF_UP   = WIDTH'(1);
  localparam logic [WIDTH-1:0]     DIFF_DOWN = '1;
  localparam logic [POS_WIDTH-1:0] POS_ONE   = POS_WIDTH'(1);

  state_e                 state_q,     state_d;
  logic [WIDTH-1:0]       prev_gray_q, prev_gray_d;
  logic [WIDTH-1:0]       binario_q,   binario_d;
  logic                   up_q,        up_d;
  logic                   down_q,      down_d;
  logic                   error_q,     error_d;
  logic                   fault_q,     fault_d;
  logic [POS_WIDTH-1:0]   position_q,  position_d;

  logic [WIDTH-1:0]       cur_bin;
  logic [WIDTH-1:0]       prev_bin;
  logic [WIDTH-1:0]       diff;
  step_e                  step;

  gray_to_bin #(.WIDTH(WIDTH)) u_cur_g2b (
    .gray_i (gray_in),
    .bin_o  (cur_bin)
  );

  gray_to_bin #(.WIDTH(WIDTH)) u_prev_g2b (
    .gray_i (prev_gray_q),
    .bin_o  (prev_bin)
  );

  // Modular difference: truncation to WIDTH bits gives the wrap for free.
  assign diff = cur_bin - prev_bin;

  always_comb begin
    step = STEP_ILLEGAL;
    if (diff == '0)            step = STEP_NONE;
    else if (diff == DIFF_UP)  step = STEP_UP;
    else if (diff == DIFF_DOWN) step = STEP_DOWN;
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // it unassigned; that is what keeps always_comb from inferring a latch.
    state_d     = state_q;
    prev_gray_d = prev_gray_q;
    binario_d   = binario_q;
    up_d        = 1'b0;
    down_d      = 1'b0;
    error_d     = 1'b0;
    position_d  = position_q;

    if (sample_en) begin
      prev_gray_d = gray_in;
      binario_d   = cur_bin;
    end

    unique case (state_q)
      WAIT_FIRST: begin
        if (sample_en) state_d = TRACK;
      end
      TRACK: begin
        if (sample_en) begin
          unique case (step)
            STEP_NONE: ;
            STEP_UP: begin
              up_d       = 1'b1;
              position_d = position_q + POS_ONE;
            end
            STEP_DOWN: begin
              down_d     = 1'b1;
              position_d = position_q - POS_ONE;
            end
            STEP_ILLEGAL: begin
              error_d = 1'b1;
              state_d = FAULT;
            end
            default: ;
          endcase
        end
      end
      FAULT: begin
        // A sample on the clearing edge still only resyncs.
        if (clear_fault) state_d = TRACK;
      end
      default: state_d = WAIT_FIRST;
    endcase

    fault_d = (state_d == FAULT);
  end

  // NOTE: sequential state is written with non-blocking assignments so all
  // flops update together on the edge, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= WAIT_FIRST;
      prev_gray_q <= '0;
      binario_q   <= '0;
      up_q        <= 1'b0;
      down_q      <= 1'b0;
      error_q     <= 1'b0;
      fault_q     <= 1'b0;
      position_q  <= '0;
    end else begin
      state_q     <= state_d;
      prev_gray_q <= prev_gray_d;
      binario_q   <= binario_d;
      up_q        <= up_d;
      down_q      <= down_d;
      error_q     <= error_d;
      fault_q     <= fault_d;
      position_q  <= position_d;
    end
  end

  assign binario  = binario_q;
  assign up       = up_q;
  assign down     = down_q;
  assign error    = error_q;
  assign fault    = fault_q;
  assign position = position_q;

endmodule : gray_step_decoder

// File: tb/tb_gray_step_decoder.sv
// Directed self-checking bench for gray_step_decoder (WIDTH=3, POS_WIDTH=8).
// Inputs change on the falling edge; outputs are checked 1 ns after the rising edge.
module tb_gray_step_decoder;

  localparam int WIDTH     = 3;
  localparam int POS_WIDTH = 8;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [WIDTH-1:0]     gray_in;
  logic                 sample_en;
  logic                 clear_fault;
  logic [WIDTH-1:0]     binario;
  logic                 up;
  logic                 down;
  logic                 error;
  logic                 fault;
  logic [POS_WIDTH-1:0] position;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  gray_step_decoder #(.WIDTH(WIDTH), .POS_WIDTH(POS_WIDTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .gray_in     (gray_in),
    .sample_en   (sample_en),
    .clear_fault (clear_fault),
    .binario     (binario),
    .up          (up),
    .down        (down),
    .error       (error),
    .fault       (fault),
    .position    (position)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [2:0] e_bin, input logic e_up,
                            input logic e_down, input logic e_err, input logic e_fault,
                            input logic [7:0] e_pos);
    check({tag, ".binario"},  32'(binario),  32'(e_bin));
    check({tag, ".up"},       32'(up),       32'(e_up));
    check({tag, ".down"},     32'(down),     32'(e_down));
    check({tag, ".error"},    32'(error),    32'(e_err));
    check({tag, ".fault"},    32'(fault),    32'(e_fault));
    check({tag, ".position"}, 32'(position), 32'(e_pos));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    sample_en = 1'b0;
    clear_fault = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One edge with the given Gray sample (and optional clear_fault).
  task automatic sample(input logic [2:0] g, input logic clr);
    @(negedge clk);
    gray_in     = g;
    sample_en   = 1'b1;
    clear_fault = clr;
    @(posedge clk);
    #1;
    sample_en   = 1'b0;
    clear_fault = 1'b0;
  endtask

  // One edge with no sample, optionally pulsing clear_fault.
  task automatic idle(input logic clr);
    @(negedge clk);
    sample_en   = 1'b0;
    clear_fault = clr;
    @(posedge clk);
    #1;
    clear_fault = 1'b0;
  endtask

  logic [2:0] up_seq   [8] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
  logic [2:0] up_bin   [8] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};

  initial begin
    reset       = 1'b1;
    gray_in     = '0;
    sample_en   = 1'b0;
    clear_fault = 1'b0;
    #2;
    check_outs("reset", 3'd0, 0, 0, 0, 0, 8'd0);
    @(negedge clk);
    reset = 1'b0;

    // First sample after reset: conversion only, no pulse.
    sample(3'b011, 0);
    check_outs("first_011", 3'd2, 0, 0, 0, 0, 8'd0);
    sample(3'b010, 0);
    check_outs("track_up", 3'd3, 1, 0, 0, 0, 8'd1);

    // Full up cycle from 000, back-to-back pulses and binary wrap 7 -> 0.
    do_reset();
    sample(3'b000, 0);
    check_outs("first_000", 3'd0, 0, 0, 0, 0, 8'd0);
    for (int i = 0; i < 8; i++) begin
      sample(up_seq[i], 0);
      check_outs($sformatf("up_seq%0d", i), up_bin[i], 1, 0, 0, 0, 8'(i + 1));
    end
    idle(0);
    check_outs("idle_drop", 3'd0, 0, 0, 0, 0, 8'd8);

    // Down step wraps position below zero, then up wraps it back.
    do_reset();
    sample(3'b000, 0);
    sample(3'b100, 0);
    check_outs("down_wrap", 3'd7, 0, 1, 0, 0, 8'hFF);
    sample(3'b000, 0);
    check_outs("up_unwrap", 3'd0, 1, 0, 0, 0, 8'd0);

    // Illegal jump, resync in FAULT, clear, then resume tracking.
    sample(3'b011, 0);
    check_outs("illegal", 3'd2, 0, 0, 1, 1, 8'd0);
    sample(3'b010, 0);
    check_outs("fault_resync", 3'd3, 0, 0, 0, 1, 8'd0);
    idle(1);
    check_outs("clear", 3'd3, 0, 0, 0, 0, 8'd0);
    sample(3'b110, 0);
    check_outs("after_clear", 3'd4, 1, 0, 0, 0, 8'd1);

    // Repeated identical samples produce nothing.
    for (int i = 0; i < 3; i++) begin
      sample(3'b110, 0);
      check_outs($sformatf("repeat%0d", i), 3'd4, 0, 0, 0, 0, 8'd1);
    end

    // clear_fault is ignored while tracking.
    sample(3'b111, 1);
    check_outs("clear_in_track", 3'd5, 1, 0, 0, 0, 8'd2);

    // Fault with a sample on the clearing edge: resync only, no pulse.
    sample(3'b000, 0);
    check_outs("illegal_diff3", 3'd0, 0, 0, 1, 1, 8'd2);
    sample(3'b001, 1);
    check_outs("clear_with_sample", 3'd1, 0, 0, 0, 0, 8'd2);
    sample(3'b011, 0);
    check_outs("post_clear_up", 3'd2, 1, 0, 0, 0, 8'd3);

    // Asynchronous reset mid-cycle while an up pulse is showing.
    sample(3'b010, 0);
    check_outs("pre_reset_up", 3'd3, 1, 0, 0, 0, 8'd4);
    #1;
    reset = 1'b1;
    #1;
    check_outs("async_reset", 3'd0, 0, 0, 0, 0, 8'd0);
    @(negedge clk);
    reset = 1'b0;
    sample(3'b100, 0);
    check_outs("first_after_reset", 3'd7, 0, 0, 0, 0, 8'd0);
    sample(3'b000, 0);
    check_outs("track_after_reset", 3'd0, 1, 0, 0, 0, 8'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_gray_step_decoder
